// File: rtl/aes_encipher_block.sv
// Iterative AES-128/256 encipher datapath: one 128-bit block, one sbox word per cycle.
// Round keys come from an external key expansion indexed by the round output.
module aes_encipher_block #(
  parameter int NUM_ROUNDS_128 = 10,
  parameter int NUM_ROUNDS_256 = 14
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         next,
  input  logic         keylen,
  input  logic         key_ready,
  input  logic [127:0] block,
  output logic [3:0]   round,
  input  logic [127:0] round_key,
  output logic [31:0]  sboxw,
  input  logic [31:0]  new_sboxw,
  output logic [127:0] new_block,
  output logic         ready
);

  // Start handshake: a request is taken only when next, ready and key_ready
  // are all high at the same rising edge; anything else is dropped, never queued.
  typedef enum logic [1:0] {IDLE, INIT, SBOX, MAIN} state_t;

  state_t       state_q, state_d;
  logic [127:0] st_q, st_d;
  logic [127:0] new_block_q, new_block_d;
  logic         ready_q, ready_d;
  logic [3:0]   round_q, round_d;
  logic [1:0]   word_ctr_q, word_ctr_d;
  logic         keylen_q, keylen_d;
  logic [3:0]   nr;
  logic [127:0] shifted;
  logic [127:0] main_result;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_word(input logic [31:0] w);
    logic [7:0] b0, b1, b2, b3;
    b0 = w[31:24];
    b1 = w[23:16];
    b2 = w[15:8];
    b3 = w[7:0];
    return {xtime(b0) ^ xtime(b1) ^ b1 ^ b2 ^ b3,
            b0 ^ xtime(b1) ^ xtime(b2) ^ b2 ^ b3,
            b0 ^ b1 ^ xtime(b2) ^ xtime(b3) ^ b3,
            xtime(b0) ^ b0 ^ b1 ^ b2 ^ xtime(b3)};
  endfunction

  // Byte n lives at bits [127-8n -: 8]; row = n%4, column = n/4.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        o[127 - 8*(r + 4*c) -: 8] = s[127 - 8*(r + 4*((c + r) % 4)) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      o[127 - 32*c -: 32] = mix_word(s[127 - 32*c -: 32]);
    end
    return o;
  endfunction

  assign nr          = keylen_q ? 4'(NUM_ROUNDS_256) : 4'(NUM_ROUNDS_128);
  assign shifted     = shift_rows(st_q);
  assign main_result = ((round_q == nr) ? shifted : mix_columns(shifted)) ^ round_key;

  assign round     = round_q;
  assign new_block = new_block_q;
  assign ready     = ready_q;
  assign sboxw     = st_q[127 - 32*int'(word_ctr_q) -: 32];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      st_q        <= '0;
      new_block_q <= '0;
      ready_q     <= 1'b1;
      round_q     <= '0;
      word_ctr_q  <= '0;
      keylen_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      st_q        <= st_d;
      new_block_q <= new_block_d;
      ready_q     <= ready_d;
      round_q     <= round_d;
      word_ctr_q  <= word_ctr_d;
      keylen_q    <= keylen_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    st_d        = st_q;
    new_block_d = new_block_q;
    ready_d     = ready_q;
    round_d     = round_q;
    word_ctr_d  = word_ctr_q;
    keylen_d    = keylen_q;
    case (state_q)
      IDLE: begin
        if (next && ready_q && key_ready) begin
          st_d     = block;
          keylen_d = keylen;
          ready_d  = 1'b0;
          round_d  = '0;
          state_d  = INIT;
        end
      end
      INIT: begin
        st_d       = st_q ^ round_key;
        round_d    = 4'd1;
        word_ctr_d = '0;
        state_d    = SBOX;
      end
      SBOX: begin
        st_d[127 - 32*int'(word_ctr_q) -: 32] = new_sboxw;
        word_ctr_d = word_ctr_q + 2'd1;
        if (word_ctr_q == 2'd3) state_d = MAIN;
      end
      MAIN: begin
        st_d = main_result;
        if (round_q == nr) begin
          new_block_d = main_result;
          ready_d     = 1'b1;
          round_d     = '0;
          state_d     = IDLE;
        end else begin
          round_d = round_q + 4'd1;
          state_d = SBOX;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_aes_encipher_block.sv
// Bench for aes_encipher_block: stands in for the key expansion and sbox, and
// compares every ciphertext with a byte-level AES model and with known vectors.
module tb_aes_encipher_block;

  logic         clk = 1'b0;
  logic         reset;
  logic         next;
  logic         keylen;
  logic         key_ready;
  logic [127:0] block;
  logic [3:0]   round;
  logic [127:0] round_key;
  logic [31:0]  sboxw;
  logic [31:0]  new_sboxw;
  logic [127:0] new_block;
  logic         ready;

  logic [7:0]   sbox_tab[256];
  logic [127:0] rk[16];
  logic [127:0] exp_q[$];
  int           n_checks = 0;
  int           n_pass = 0;

  aes_encipher_block dut (
    .clk(clk), .reset(reset), .next(next), .keylen(keylen), .key_ready(key_ready),
    .block(block), .round(round), .round_key(round_key), .sboxw(sboxw),
    .new_sboxw(new_sboxw), .new_block(new_block), .ready(ready)
  );

  always #1 clk = ~clk;

  assign round_key = rk[round];
  assign new_sboxw = {sbox_tab[sboxw[31:24]], sbox_tab[sboxw[23:16]],
                      sbox_tab[sboxw[15:8]], sbox_tab[sboxw[7:0]]};

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    logic [7:0] bb;
    p = 8'h00;
    aa = a;
    bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? (({aa[6:0], 1'b0}) ^ 8'h1b) : {aa[6:0], 1'b0};
      bb = bb >> 1;
    end
    return p;
  endfunction

  // Sbox from its definition: multiplicative inverse then the affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    logic [7:0] b;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h01;
      for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(x));
      if (x == 0) inv = 8'h00;
      b = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
          ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sbox_tab[x] = b;
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox_tab[w[31:24]], sbox_tab[w[23:16]], sbox_tab[w[15:8]], sbox_tab[w[7:0]]};
  endfunction

  task automatic load_key(input logic [255:0] key, input logic kl);
    logic [31:0] w[60];
    logic [31:0] temp;
    logic [7:0]  rc;
    int nk;
    int nr;
    nk = kl ? 8 : 4;
    nr = kl ? 14 : 10;
    rc = 8'h01;
    for (int i = 0; i < 60; i++) w[i] = '0;
    for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
    for (int i = nk; i < 4*(nr + 1); i++) begin
      temp = w[i-1];
      if (i % nk == 0) begin
        temp = sub_word({temp[23:0], temp[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk == 8 && i % nk == 4) begin
        temp = sub_word(temp);
      end
      w[i] = w[i-nk] ^ temp;
    end
    for (int r = 0; r < 16; r++) rk[r] = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : '0;
  endtask

  function automatic logic [127:0] aes_model(input logic [127:0] pt, input int nr);
    logic [7:0] s[16];
    logic [7:0] t[16];
    logic [127:0] o;
    for (int i = 0; i < 16; i++) s[i] = pt[127 - 8*i -: 8] ^ rk[0][127 - 8*i -: 8];
    for (int r = 1; r <= nr; r++) begin
      for (int i = 0; i < 16; i++) s[i] = sbox_tab[s[i]];
      for (int row = 0; row < 4; row++)
        for (int col = 0; col < 4; col++)
          t[row + 4*col] = s[row + 4*((col + row) % 4)];
      for (int c = 0; c < 4; c++) begin
        if (r != nr) begin
          s[4*c]   = gmul(t[4*c], 8'h02) ^ gmul(t[4*c+1], 8'h03) ^ t[4*c+2] ^ t[4*c+3];
          s[4*c+1] = t[4*c] ^ gmul(t[4*c+1], 8'h02) ^ gmul(t[4*c+2], 8'h03) ^ t[4*c+3];
          s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2], 8'h02) ^ gmul(t[4*c+3], 8'h03);
          s[4*c+3] = gmul(t[4*c], 8'h03) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3], 8'h02);
        end else begin
          for (int k = 0; k < 4; k++) s[4*c+k] = t[4*c+k];
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[r][127 - 8*i -: 8];
    end
    o = '0;
    for (int i = 0; i < 16; i++) o[127 - 8*i -: 8] = s[i];
    return o;
  endfunction

  // One encryption; optional stray next pulses and input toggling while busy.
  task automatic run_op(input logic [127:0] pt, input logic kl, input int pulse_a,
                        input int pulse_b, input bit toggle, input string name,
                        output logic [127:0] res);
    int cnt;
    int exp_lat;
    logic [127:0] prev_nb;
    logic [127:0] exp;
    exp_lat = kl ? 71 : 51;
    exp_q.push_back(aes_model(pt, kl ? 14 : 10));
    @(negedge clk);
    prev_nb = new_block;
    block = pt;
    keylen = kl;
    next = 1'b1;
    @(posedge clk);
    @(negedge clk);
    next = 1'b0;
    n_checks++;
    if (ready !== 1'b0) $display("FAIL %s busy: ready=%b required 0", name, ready);
    else n_pass++;
    cnt = 0;
    while (ready !== 1'b1 && cnt < 200) begin
      @(posedge clk);
      cnt++;
      @(negedge clk);
      next = (cnt == pulse_a || cnt == pulse_b) ? 1'b1 : 1'b0;
      if (toggle) begin
        keylen = ~keylen;
        block = {$urandom, $urandom, $urandom, $urandom};
      end
      if (cnt == 25) begin
        n_checks++;
        if (new_block !== prev_nb) $display("FAIL %s hold: new_block=%h required %h", name, new_block, prev_nb);
        else n_pass++;
      end
    end
    next = 1'b0;
    n_checks++;
    if (cnt != exp_lat) $display("FAIL %s latency: got %0d required %0d", name, cnt, exp_lat);
    else n_pass++;
    exp = exp_q.pop_front();
    n_checks++;
    if (new_block !== exp) $display("FAIL %s result: got %h required %h", name, new_block, exp);
    else n_pass++;
    res = new_block;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (ready !== 1'b1) $display("FAIL reset ready: got %b required 1", ready);
    else n_pass++;
    n_checks++;
    if (new_block !== 128'h0) $display("FAIL reset new_block: got %h required 0", new_block);
    else n_pass++;
    n_checks++;
    if (round !== 4'h0) $display("FAIL reset round: got %0d required 0", round);
    else n_pass++;
    reset = 1'b0;
  endtask

  task automatic test_known_vectors();
    logic [127:0] res;
    load_key({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 1'b0);
    run_op(128'h00112233445566778899aabbccddeeff, 1'b0, -1, -1, 1'b0, "t1", res);
    n_checks++;
    if (res !== 128'h69c4e0d86a7b0430d8cdb78070b4c55a) $display("FAIL t1 vector: got %h required 69c4e0d86a7b0430d8cdb78070b4c55a", res);
    else n_pass++;
    load_key({128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 1'b0);
    run_op(128'h6bc1bee22e409f96e93d7e117393172a, 1'b0, -1, -1, 1'b0, "t3", res);
    n_checks++;
    if (res !== 128'h3ad77bb40d7a3660a89ecaf32466ef97) $display("FAIL t3 vector: got %h required 3ad77bb40d7a3660a89ecaf32466ef97", res);
    else n_pass++;
    load_key(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 1'b1);
    run_op(128'h00112233445566778899aabbccddeeff, 1'b1, -1, -1, 1'b0, "t2", res);
    n_checks++;
    if (res !== 128'h8ea2b7ca516745bfeafc49904b496089) $display("FAIL t2 vector: got %h required 8ea2b7ca516745bfeafc49904b496089", res);
    else n_pass++;
  endtask

  task automatic test_ignored_next();
    logic [127:0] res;
    load_key({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 1'b0);
    run_op(128'h00112233445566778899aabbccddeeff, 1'b0, 10, 20, 1'b0, "busy_next", res);
    @(negedge clk);
    key_ready = 1'b0;
    next = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (ready !== 1'b1 || round !== 4'h0) $display("FAIL key_not_ready: ready=%b round=%0d required 1/0", ready, round);
      else n_pass++;
    end
    next = 1'b0;
    key_ready = 1'b1;
  endtask

  task automatic test_reset_abort();
    logic [127:0] res;
    int cnt;
    load_key({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 1'b0);
    @(negedge clk);
    block = 128'h00112233445566778899aabbccddeeff;
    keylen = 1'b0;
    next = 1'b1;
    @(posedge clk);
    @(negedge clk);
    next = 1'b0;
    cnt = 0;
    while (round !== 4'd5 && cnt < 200) begin
      @(posedge clk);
      cnt++;
      @(negedge clk);
    end
    n_checks++;
    if (round !== 4'd5) $display("FAIL abort reach_round5: round=%0d required 5", round);
    else n_pass++;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    n_checks++;
    if (ready !== 1'b1 || new_block !== 128'h0 || round !== 4'h0)
      $display("FAIL abort state: ready=%b new_block=%h round=%0d required 1/0/0", ready, new_block, round);
    else n_pass++;
    run_op(128'h00112233445566778899aabbccddeeff, 1'b0, -1, -1, 1'b0, "after_abort", res);
  endtask

  task automatic test_input_toggle();
    logic [127:0] res;
    load_key(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 1'b1);
    run_op(128'h00112233445566778899aabbccddeeff, 1'b1, -1, -1, 1'b1, "toggle", res);
    n_checks++;
    if (res !== 128'h8ea2b7ca516745bfeafc49904b496089) $display("FAIL toggle vector: got %h required 8ea2b7ca516745bfeafc49904b496089", res);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [127:0] res;
    logic [255:0] key;
    logic kl;
    for (int i = 0; i < 8; i++) begin
      key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      kl = 1'($urandom_range(0, 1));
      load_key(key, kl);
      run_op({$urandom, $urandom, $urandom, $urandom}, kl, -1, -1, 1'($urandom_range(0, 1)), "random", res);
    end
  endtask

  initial begin
    reset = 1'b1;
    next = 1'b0;
    keylen = 1'b0;
    key_ready = 1'b1;
    block = '0;
    for (int r = 0; r < 16; r++) rk[r] = '0;
    build_sbox();
    test_reset();
    test_known_vectors();
    test_ignored_next();
    test_reset_abort();
    test_input_toggle();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
